// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word reads to imem, queues returned words for the core.
// Latency: request accepted in T -> instr_valid in T+2; redirect in T -> new-stream instr_valid in T+3.
// Backpressure: requests are credit-limited by free queue slots; instr/instr_pc hold while !instr_ready.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_err
);

  localparam int            AW = $clog2(QDEPTH);
  localparam logic [AW+1:0] QD = (AW+2)'(QDEPTH);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic          err, err_nxt;

  // One outstanding read at most per cycle; req_addr remembers which word is coming back.
  logic          inflight;
  logic [31:0]   req_addr;

  logic [31:0]   q_instr [QDEPTH];
  logic [31:0]   q_pc    [QDEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0]   count;

  logic          pop, push, accept;
  logic [AW+1:0] used, limit;

  assign instr_valid = (state == RUN) && (count != '0);
  assign pop         = instr_valid && instr_ready;
  // A response landing in the redirect cycle belongs to the old stream and is dropped.
  assign push        = inflight && !redirect;
  assign accept      = imem_req && imem_ready;

  assign imem_addr   = pc;
  assign instr       = q_instr[head];
  assign instr_pc    = q_pc[head];
  assign fetch_err   = err;

  // Credit check: slots already claimed (queued + in flight) minus this cycle's pop must leave room.
  always_comb begin
    used  = {1'b0, count} + {{(AW+1){1'b0}}, inflight};
    limit = QD + {{(AW+1){1'b0}}, pop};
  end

  // Next-state, next-PC and request generation; redirect overrides everything.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    err_nxt   = err;
    imem_req  = 1'b0;
    if (rst && (state == RUN) && !redirect && (used < limit)) begin
      imem_req = 1'b1;
    end
    if (redirect) begin
      pc_nxt = {redirect_pc[31:2], 2'b00};
      if (redirect_pc[1:0] == 2'b00) begin
        state_nxt = RUN;
        err_nxt   = 1'b0;
      end else begin
        state_nxt = HALT;
        err_nxt   = 1'b1;
      end
    end else if (imem_req && imem_ready) begin
      pc_nxt = pc + 32'd4;
    end
  end

  // FSM state, fetch PC and sticky error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      err   <= err_nxt;
    end
  end

  // Track the single outstanding read; no request is accepted in a redirect cycle, so none survives it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      req_addr <= '0;
    end else begin
      inflight <= accept;
      if (accept) begin
        req_addr <= pc;
      end
    end
  end

  // Instruction queue: circular buffer with flush on redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr[i] <= '0;
        q_pc[i]    <= '0;
      end
    end else if (redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_instr[tail] <= imem_rdata;
        q_pc[tail]    <= req_addr;
        tail          <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue-based reference model plus directed scenarios and a random phase.
// Memory returns addr ^ 32'hA5A5_0000 one cycle after acceptance, garbage otherwise.
// Inputs change 1 time unit after posedge; outputs are compared on the negedge.
module tb_fetch_unit;

  localparam logic [31:0] K  = 32'hA5A5_0000;
  localparam int          QD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_ready, instr_valid, instr_ready, redirect, fetch_err;
  logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;

  int total = 0;
  int bad   = 0;

  // Reference model: queue of {pc, word}, one optional in-flight address, fetch pc, halt/err flags.
  bit          m_halt, m_err, m_inf;
  logic [31:0] m_pc, m_inf_addr;
  logic [63:0] m_q[$];

  // Observations of the last checked cycle.
  logic        o_req, o_valid, o_err;
  logic [31:0] o_addr, o_pc, o_instr;

  logic [31:0] got[$];
  int          nreq;
  bit          seen8;
  int          rdy_pat[4] = '{1, 0, 0, 1};

  fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr), .instr_pc(instr_pc),
    .redirect(redirect), .redirect_pc(redirect_pc), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Synchronous memory: data valid exactly one cycle after acceptance.
  initial begin
    bit          acc;
    logic [31:0] a;
    imem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      acc = imem_req && imem_ready;
      a   = imem_addr;
      @(posedge clk);
      #1;
      imem_rdata = acc ? (a ^ K) : $urandom;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_inf  = 1'b0;
    m_halt = 1'b0;
    m_err  = 1'b0;
    m_pc   = 32'h0000_0000;
  endtask

  // One cycle: compare DUT outputs with the model on the negedge, advance the model, return after posedge.
  task automatic tick();
    bit ev, pop, er, acc;
    int used;
    @(negedge clk);
    if (!rst) model_reset();
    ev   = !m_halt && (m_q.size() != 0);
    pop  = ev && instr_ready;
    used = m_q.size() + int'(m_inf) - int'(pop);
    er   = rst && !m_halt && !redirect && (used < QD);
    o_req = imem_req; o_addr = imem_addr; o_valid = instr_valid;
    o_pc  = instr_pc; o_instr = instr;    o_err = fetch_err;
    chk("imem_req", imem_req, er);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_valid", instr_valid, ev);
    if (ev) begin
      chk("instr", instr, m_q[0][31:0]);
      chk("instr_pc", instr_pc, m_q[0][63:32]);
    end
    chk("fetch_err", fetch_err, m_err);
    if (rst) begin
      if (redirect) begin
        m_q.delete();
        m_inf = 1'b0;
        m_pc  = {redirect_pc[31:2], 2'b00};
        if (redirect_pc[1:0] == 2'b00) begin
          m_halt = 1'b0;
          m_err  = 1'b0;
        end else begin
          m_halt = 1'b1;
          m_err  = 1'b1;
        end
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_inf) m_q.push_back({m_inf_addr, m_inf_addr ^ K});
        acc   = er && imem_ready;
        m_inf = acc;
        if (acc) begin
          m_inf_addr = m_pc;
          m_pc       = m_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rv;
    int          r;
    rst = 1'b0; imem_ready = 1'b1; instr_ready = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset values
    tick();
    chk("rst_req", o_req, 1'b0);
    chk("rst_addr", o_addr, 32'h0);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_pc", o_pc, 32'h0);
    chk("rst_err", o_err, 1'b0);

    // Sequential fetch from RESET_PC
    rst = 1'b1;
    tick(); chk("seq_c0_req", o_req, 1'b1); chk("seq_c0_addr", o_addr, 32'h0);
    tick(); chk("seq_c1_valid", o_valid, 1'b0);
    tick(); chk("seq_c2_valid", o_valid, 1'b1); chk("seq_c2_pc", o_pc, 32'h0);
    tick(); chk("seq_c3_pc", o_pc, 32'h4);
    tick(); chk("seq_c4_pc", o_pc, 32'h8); chk("seq_c4_instr", o_instr, 32'hA5A5_0008);

    // Reset mid-stream: valid must drop asynchronously
    chk("rmid_pre_valid", instr_valid, 1'b1);
    rst = 1'b0;
    #1;
    chk("rmid_async_drop", instr_valid, 1'b0);
    tick();
    rst = 1'b1;
    tick(); tick(); tick();
    chk("rmid_first_valid", o_valid, 1'b1);
    chk("rmid_first_pc", o_pc, 32'h0);

    // Backpressure: core stalls for 10 cycles
    do_reset();
    instr_ready = 1'b0;
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (o_req && imem_ready) nreq++;
    end
    chk("bp_nreq", nreq, 2);
    chk("bp_hold_valid", o_valid, 1'b1);
    chk("bp_hold_pc", o_pc, 32'h0);
    instr_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_valid) got.push_back(o_pc);
    end
    chk("bp_seq0", got[0], 32'h0);
    chk("bp_seq1", got[1], 32'h4);
    chk("bp_seq2", got[2], 32'h8);

    // Redirect with pc 8 in flight
    do_reset();
    tick(); tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0;
    seen8 = (o_valid && o_pc == 32'h8);
    tick(); chk("rd_t1_valid", o_valid, 1'b0); chk("rd_t1_req", o_req, 1'b1); chk("rd_t1_addr", o_addr, 32'h100);
    tick(); chk("rd_t2_valid", o_valid, 1'b0);
    tick(); chk("rd_t3_valid", o_valid, 1'b1); chk("rd_t3_pc", o_pc, 32'h100);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (o_valid && o_pc == 32'h8) seen8 = 1'b1;
    end
    chk("rd_never_pc8", seen8, 1'b0);

    // Misaligned redirect halts fetch until an aligned redirect
    redirect = 1'b1; redirect_pc = 32'h0000_0102;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      imem_ready  = ($urandom_range(0, 1) == 1);
      instr_ready = ($urandom_range(0, 1) == 1);
      tick();
      chk("halt_err", o_err, 1'b1);
      chk("halt_req", o_req, 1'b0);
      chk("halt_valid", o_valid, 1'b0);
    end
    imem_ready = 1'b1; instr_ready = 1'b1;
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    tick(); chk("resume_err", o_err, 1'b0); chk("resume_req", o_req, 1'b1); chk("resume_addr", o_addr, 32'h200);
    tick();
    tick(); chk("resume_valid", o_valid, 1'b1); chk("resume_pc", o_pc, 32'h200);

    // Memory stall and address wrap
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    got.delete();
    for (int i = 0; i < 10; i++) begin
      imem_ready = (i < 4) ? (rdy_pat[i] != 0) : 1'b1;
      tick();
      if (i >= 1 && i <= 3) chk("wrap_hold_addr", o_addr, 32'hFFFF_FFFC);
      if (i == 1 || i == 2) chk("wrap_hold_req", o_req, 1'b1);
      if (o_valid) got.push_back(o_pc);
    end
    chk("wrap_seq0", got[0], 32'hFFFF_FFF8);
    chk("wrap_seq1", got[1], 32'hFFFF_FFFC);
    chk("wrap_seq2", got[2], 32'h0000_0000);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      imem_ready  = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      rst         = ($urandom_range(0, 199) != 0);
      rv = $urandom;
      r  = $urandom_range(0, 9);
      if (r == 0)      redirect_pc = (rv[1:0] == 2'b00) ? {rv[31:2], 2'b10} : rv;
      else if (r == 1) redirect_pc = 32'hFFFF_FFF0;
      else             redirect_pc = {rv[31:2], 2'b00};
      tick();
    end
    rst = 1'b1; redirect = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
